knn_result_reader: RTL and testbench

//  Read side of the KNN accelerator's CPU bus. The write side loads the test and data points and fills the
//  K-entry neighbour list. This block runs the majority vote over that list when the write side signals

---
 rtl/knn_result_reader_pkg.sv | 31 +++
 rtl/knn_vote_hist.sv | 38 +++
 rtl/knn_result_reader.sv | 173 +++++++++++++++++
 tb/tb_knn_result_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/knn_result_reader_pkg.sv
// Shared KNN read-side definitions: sizing defaults, FSM states, register map.
// No logic of its own; imported by the vote histogram and the result reader.
// Vote-counter width derives from the neighbour-list depth so it can never overflow.
package knn_result_reader_pkg;

   localparam int KNN_DATA_W  = 32;
   localparam int KNN_K       = 4;
   localparam int KNN_C       = 8;
   localparam int KNN_LABEL_W = $clog2(KNN_C);
   localparam int KNN_ADDR_W  = 2;

   // A class can collect at most K votes, so K+1 distinct counts must be representable.
   function automatic int knn_vote_w(input int k);
      return $clog2(k + 1);
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_SCAN  = 3'd2,
      ST_VOTE  = 3'd3,
      ST_DONE  = 3'd4
   } knn_state_t;

   // Read-only register map
   localparam int REG_STATUS = 0;
   localparam int REG_RESULT = 1;
   localparam int REG_VOTES  = 2;
   localparam int REG_RSVD   = 3;

endpackage

// File: rtl/knn_vote_hist.sv
// Per-class vote histogram: C counters with sync clear, increment-by-index, read-by-index.
// Latency: increment/clear take effect at the next edge; the read port is combinational.
// No backpressure: every clear/increment is accepted in the cycle it is presented.
module knn_vote_hist
   import knn_result_reader_pkg::*;
#(
   parameter int C     = KNN_C,
   parameter int IDX_W = KNN_LABEL_W,
   parameter int CNT_W = knn_vote_w(KNN_K)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc_en,
   input  logic [IDX_W-1:0] i_inc_idx,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic [CNT_W-1:0] o_rd_cnt
);

   logic [CNT_W-1:0] r_cnt [C];

   // Counter bank: clear wins over increment; only the addressed counter moves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < C; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < C; i++) begin
            if (i_clr)
               r_cnt[i] <= '0;
            else if (i_inc_en && (i_inc_idx == IDX_W'(i)))
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
         end
      end
   end

   assign o_rd_cnt = r_cnt[i_rd_idx];

endmodule

// File: rtl/knn_result_reader.sv
// KNN read side: majority vote over the neighbour list, then CPU reads of status/label/votes.
// Latency: classify -> done after K+C+2 edges; reads answer one cycle after the request.
// Backpressure: RESULT/VOTES reads stall (ready held low) while a vote is running.
module knn_result_reader
   import knn_result_reader_pkg::*;
#(
   parameter int DATA_W  = KNN_DATA_W,
   parameter int K       = KNN_K,
   parameter int C       = KNN_C,
   parameter int LABEL_W = KNN_LABEL_W,
   parameter int ADDR_W  = KNN_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     address,
   input  logic [3:0]            wstrb,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ready,
   input  logic                  classify,
   output logic [$clog2(K)-1:0]  nb_idx,
   input  logic [LABEL_W-1:0]    nb_label,
   input  logic                  nb_valid,
   output logic                  busy,
   output logic                  done
);

   localparam int NBI_W  = $clog2(K);
   localparam int VCNT_W = knn_vote_w(K);
   localparam int VIDX_W = LABEL_W + 1;   // one extra bit to mark "all classes issued"

   localparam logic [NBI_W-1:0]   SCAN_LAST = NBI_W'(K - 1);
   localparam logic [VIDX_W-1:0]  VOTE_END  = VIDX_W'(C);
   localparam logic [LABEL_W-1:0] LBL_LAST  = LABEL_W'(C - 1);
   localparam logic [ADDR_W-1:0]  A_STATUS  = ADDR_W'(REG_STATUS);
   localparam logic [ADDR_W-1:0]  A_RESULT  = ADDR_W'(REG_RESULT);
   localparam logic [ADDR_W-1:0]  A_VOTES   = ADDR_W'(REG_VOTES);

   knn_state_t          r_state, w_state_nxt;
   logic [NBI_W-1:0]    r_scan_idx;
   logic [VIDX_W-1:0]   r_vote_idx;
   logic                r_cand_vld;
   logic [LABEL_W-1:0]  r_cand_lbl;
   logic [VCNT_W-1:0]   r_cand_cnt;
   logic [LABEL_W-1:0]  r_best_lbl;
   logic [VCNT_W-1:0]   r_best_cnt;
   logic [VCNT_W-1:0]   w_hist_cnt;
   logic                r_ready;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_served;
   logic                w_busy;
   logic                w_done;
   logic                w_rd_req;
   logic                w_rd_stall;
   logic                w_rd_go;
   logic [DATA_W-1:0]   w_rd_dat;

   knn_vote_hist #(
      .C     (C),
      .IDX_W (LABEL_W),
      .CNT_W (VCNT_W)
   ) u_hist (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (r_state == ST_CLEAR),
      .i_inc_en  ((r_state == ST_SCAN) && nb_valid),
      .i_inc_idx (nb_label),
      .i_rd_idx  (r_vote_idx[LABEL_W-1:0]),
      .o_rd_cnt  (w_hist_cnt)
   );

   // State register; reset aborts any vote in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: classify only starts a vote from IDLE or DONE, ignored while busy.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (classify) w_state_nxt = ST_CLEAR;
         ST_CLEAR: w_state_nxt = ST_SCAN;
         ST_SCAN:  if (r_scan_idx == SCAN_LAST) w_state_nxt = ST_VOTE;
         ST_VOTE:  if (r_cand_vld && (r_cand_lbl == LBL_LAST)) w_state_nxt = ST_DONE;
         ST_DONE:  if (classify) w_state_nxt = ST_CLEAR;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_busy = (r_state == ST_CLEAR) || (r_state == ST_SCAN) || (r_state == ST_VOTE);
   assign w_done = (r_state == ST_DONE);
   assign busy   = w_busy;
   assign done   = w_done;
   assign nb_idx = (r_state == ST_SCAN) ? r_scan_idx : '0;

   // Neighbour-list walk: one entry per cycle during SCAN, parked at 0 otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_scan_idx <= '0;
      else if ((r_state == ST_SCAN) && (r_scan_idx != SCAN_LAST))
         r_scan_idx <= r_scan_idx + NBI_W'(1);
      else
         r_scan_idx <= '0;
   end

   // Vote issue stage: read one class counter per cycle into a candidate register,
   // so the compare below sees a registered count (one extra cycle at the tail of VOTE).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vote_idx <= '0;
         r_cand_vld <= 1'b0;
         r_cand_lbl <= '0;
         r_cand_cnt <= '0;
      end else if ((r_state == ST_VOTE) && (r_vote_idx != VOTE_END)) begin
         r_vote_idx <= r_vote_idx + VIDX_W'(1);
         r_cand_vld <= 1'b1;
         r_cand_lbl <= r_vote_idx[LABEL_W-1:0];
         r_cand_cnt <= w_hist_cnt;
      end else begin
         r_cand_vld <= 1'b0;
         if (r_state != ST_VOTE) r_vote_idx <= '0;
      end
   end

   // Best-so-far: strict greater-than keeps the lowest class index on ties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_best_lbl <= '0;
         r_best_cnt <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_best_lbl <= '0;
         r_best_cnt <= '0;
      end else if ((r_state == ST_VOTE) && r_cand_vld && (r_cand_cnt > r_best_cnt)) begin
         r_best_lbl <= r_cand_lbl;
         r_best_cnt <= r_cand_cnt;
      end
   end

   // A read is answered once per valid assertion; result registers are withheld mid-vote.
   assign w_rd_req   = valid && (wstrb == 4'd0) && !r_served && !r_ready;
   assign w_rd_stall = w_busy && ((address == A_RESULT) || (address == A_VOTES));
   assign w_rd_go    = w_rd_req && !w_rd_stall;

   // Register read mux, zero-extended to the bus width.
   always_comb begin
      w_rd_dat = '0;
      if (address == A_STATUS)
         w_rd_dat = DATA_W'({w_busy, w_done});
      else if (address == A_RESULT)
         w_rd_dat = DATA_W'(r_best_lbl);
      else if (address == A_VOTES)
         w_rd_dat = DATA_W'(r_best_cnt);
   end

   // Bus response: one-cycle ready pulse, rdata held between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready  <= 1'b0;
         r_rdata  <= '0;
         r_served <= 1'b0;
      end else begin
         r_ready <= w_rd_go;
         if (w_rd_go) r_rdata <= w_rd_dat;
         if (!valid)       r_served <= 1'b0;
         else if (w_rd_go) r_served <= 1'b1;
      end
   end

   assign ready = r_ready;
   assign rdata = r_rdata;

endmodule

// File: tb/tb_knn_result_reader.sv
// Directed bench: read requests push expected data into a scoreboard queue,
// an independent monitor pops and compares on every ready pulse.
module tb_knn_result_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [1:0]  address;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;
   logic        classify;
   logic [1:0]  nb_idx;
   logic [2:0]  nb_label;
   logic        nb_valid;
   logic        busy;
   logic        done;

   logic [2:0]  tb_lbl [4];
   logic        tb_vld [4];

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q  [$];
   string       name_q [$];
   logic [31:0] last_rd = 32'd0;

   always #5 clk = ~clk;

   knn_result_reader dut (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid),
      .address  (address),
      .wstrb    (wstrb),
      .rdata    (rdata),
      .ready    (ready),
      .classify (classify),
      .nb_idx   (nb_idx),
      .nb_label (nb_label),
      .nb_valid (nb_valid),
      .busy     (busy),
      .done     (done)
   );

   // Neighbour-list model, combinational lookup at nb_idx.
   always_comb begin
      nb_label = tb_lbl[nb_idx];
      nb_valid = tb_vld[nb_idx];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got ready=1 rdata=0x%0h, expected no response", rdata);
         end else begin
            chk(name_q.pop_front(), rdata, exp_q.pop_front());
         end
      end
   end

   task automatic set_nb(input logic [2:0] l0, l1, l2, l3, input logic [3:0] vm);
      tb_lbl[0] = l0; tb_lbl[1] = l1; tb_lbl[2] = l2; tb_lbl[3] = l3;
      for (int i = 0; i < 4; i++) tb_vld[i] = vm[i];
   endtask

   // Read: push expectation, wait (bounded) for ready, check latency, hold valid to catch duplicates.
   task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] e, input int exp_lat);
      int n;
      @(negedge clk);
      valid = 1'b1; address = a; wstrb = 4'd0;
      exp_q.push_back(e);
      name_q.push_back(nm);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (ready !== 1'b1 && n < 40);
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no ready in 40 cycles, expected ready", nm);
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end else begin
         chk({nm, "_lat"}, n, exp_lat);
         last_rd = e;
      end
      repeat (3) @(negedge clk);
      valid = 1'b0;
   endtask

   // Write: must never produce ready nor disturb rdata.
   task automatic wr(input logic [1:0] a);
      int seen;
      @(negedge clk);
      valid = 1'b1; address = a; wstrb = 4'hF;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ready === 1'b1) seen++;
      end
      chk("wr_no_ready", seen, 0);
      chk("wr_rdata_hold", rdata, last_rd);
      @(negedge clk);
      valid = 1'b0; wstrb = 4'd0;
   endtask

   // Classify pulse, then bounded wait for done with latency check.
   task automatic run();
      int n;
      @(negedge clk);
      classify = 1'b1;
      @(posedge clk); #1;
      classify = 1'b0;
      chk("done_low_after_classify", done, 1'b0);
      chk("busy_after_classify", busy, 1'b1);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (done !== 1'b1 && n < 40);
      chk("done_latency", n, 14);
      chk("busy_at_done", busy, 1'b0);
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, "_busy"},   busy,   1'b0);
      chk({nm, "_done"},   done,   1'b0);
      chk({nm, "_ready"},  ready,  1'b0);
      chk({nm, "_rdata"},  rdata,  32'd0);
      chk({nm, "_nb_idx"}, nb_idx, 2'd0);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; address = '0; wstrb = '0; classify = 1'b0;
      set_nb(3'd0, 3'd0, 3'd0, 3'd0, 4'b0000);
      repeat (2) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Idle reads return reset values immediately
      rd("idle_status", 2'd0, 32'd0, 1);
      rd("idle_result", 2'd1, 32'd0, 1);
      rd("idle_votes",  2'd2, 32'd0, 1);
      rd("idle_rsvd",   2'd3, 32'd0, 1);

      // Plain majority
      set_nb(3'd2, 3'd2, 3'd5, 3'd1, 4'b1111);
      run();
      rd("t1_result", 2'd1, 32'd2, 1);
      rd("t1_votes",  2'd2, 32'd2, 1);
      rd("t1_status", 2'd0, 32'd1, 1);

      // Tie goes to the lower class; then unanimous (max count)
      set_nb(3'd3, 3'd6, 3'd6, 3'd3, 4'b1111);
      run();
      rd("tie_result", 2'd1, 32'd3, 1);
      rd("tie_votes",  2'd2, 32'd2, 1);
      set_nb(3'd7, 3'd7, 3'd7, 3'd7, 4'b1111);
      run();
      rd("all7_result", 2'd1, 32'd7, 1);
      rd("all7_votes",  2'd2, 32'd4, 1);

      // Empty list
      set_nb(3'd5, 3'd5, 3'd5, 3'd5, 4'b0000);
      run();
      rd("empty_result", 2'd1, 32'd0, 1);
      rd("empty_votes",  2'd2, 32'd0, 1);

      // RESULT read during a vote stalls until DONE, then carries the new label
      set_nb(3'd4, 3'd1, 3'd4, 3'd4, 4'b1111);
      fork
         run();
         begin
            @(negedge clk);
            rd("stall_result", 2'd1, 32'd4, 15);
         end
      join
      rd("stall_votes", 2'd2, 32'd3, 1);
      // STATUS never stalls: busy=1, done=0 mid-vote
      fork
         run();
         begin
            @(negedge clk);
            rd("busy_status", 2'd0, 32'd2, 1);
         end
      join
      rd("done_status", 2'd0, 32'd1, 1);

      // Reset in the middle of SCAN
      set_nb(3'd6, 3'd6, 3'd2, 3'd6, 4'b1111);
      @(negedge clk);
      classify = 1'b1;
      @(negedge clk);
      classify = 1'b0;
      repeat (2) @(negedge clk);
      chk("scan_busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk_outputs_zero("midscan_rst");
      @(negedge clk);
      rst = 1'b0;
      last_rd = 32'd0;
      rd("post_rst_result", 2'd1, 32'd0, 1);
      set_nb(3'd1, 3'd3, 3'd1, 3'd5, 4'b0111);
      run();
      rd("fresh_result", 2'd1, 32'd1, 1);
      rd("fresh_votes",  2'd2, 32'd2, 1);

      // Writes are ignored; reclassify from DONE with new labels
      wr(2'd1);
      set_nb(3'd0, 3'd6, 3'd6, 3'd6, 4'b1111);
      run();
      rd("reclass_result", 2'd1, 32'd6, 1);
      rd("reclass_votes",  2'd2, 32'd3, 1);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
